// File: rtl/pet_dma_pkg.sv
// Shared definitions for the PRG injection loader: loader states, RAM bounds,
// FIFO sizing and the BASIC pointer locations rewritten after a load.
// Optional feature macro: PRG_PTR_FIXUP_EN (adds the FIXUP state).
package pet_dma_pkg;

  localparam logic [7:0]  PRG_INDEX  = 8'h41;
  localparam logic [15:0] RAM_TOP    = 16'h3FFF;
  localparam int          DMA_AW     = 14;
  localparam int          DMA_DW     = 8;
  localparam int          FIFO_W     = DMA_AW + DMA_DW;
  localparam int          FIFO_DEPTH = 4;

  // BASIC zero-page pointers that must point just past the loaded program
  localparam logic [13:0] VARTAB_ADDR = 14'h002A;
  localparam logic [13:0] ARYTAB_ADDR = 14'h002C;
  localparam logic [13:0] STREND_ADDR = 14'h002E;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef PRG_PTR_FIXUP_EN
    ST_FIXUP  = 3'd4,
`endif
    ST_DONE   = 3'd5
  } state_e;

`ifdef PRG_PTR_FIXUP_EN
  // Write index 0..5 -> 2A,2B,2C,2D,2E,2F (lo byte on even, hi byte on odd)
  function automatic logic [13:0] ptr_addr(input logic [2:0] idx);
    logic [13:0] base;
    case (idx[2:1])
      2'd0:    base = VARTAB_ADDR;
      2'd1:    base = ARYTAB_ADDR;
      default: base = STREND_ADDR;
    endcase
    return base | {13'd0, idx[0]};
  endfunction
`endif

endpackage

// File: rtl/prg_fifo.sv
// Small synchronous FIFO decoupling accepted PRG bytes from the DMA write port.
// DEPTH must be a power of two so the pointers wrap naturally.
module prg_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  // Pointer and occupancy update; push+pop together leaves the count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (!wr_ok && rd_ok) count_d = count_q - 1'b1;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/prg_dma_loader.sv
// Injects a Commodore PRG file (2-byte load address + payload) from the
// ioctl download stream into PET RAM through a one-write-per-cycle DMA port.
// Optional feature macro: PRG_PTR_FIXUP_EN -- after the payload, rewrite
// VARTAB/ARYTAB/STREND with the end address of the loaded program.
module prg_dma_loader
  import pet_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [13:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        overflow
);

  state_e        state_q, state_d;
  logic          dl_prev_q, dl_prev_d;
  logic [15:0]   load_addr_q, load_addr_d;
  logic [15:0]   cur_q, cur_d;
  logic [15:0]   end_addr_q, end_addr_d;
  logic          overflow_q, overflow_d;
  logic          dma_we_q, dma_we_d;
  logic [13:0]   dma_addr_q, dma_addr_d;
  logic [7:0]    dma_din_q, dma_din_d;
`ifdef PRG_PTR_FIXUP_EN
  logic [2:0]    fix_cnt_q, fix_cnt_d;
`endif

  logic              qual_dl, byte_ok, dl_rise;
  logic [15:0]       cur_inc;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_rd_data;
  logic [13:0]       fifo_rd_addr;
  logic [7:0]        fifo_rd_din;

  assign qual_dl  = ioctl_download && (ioctl_index == PRG_INDEX);
  assign byte_ok  = ioctl_wr && qual_dl;
  assign dl_rise  = qual_dl && !dl_prev_q;
  assign cur_inc  = cur_q + 16'd1;
  assign {fifo_rd_addr, fifo_rd_din} = fifo_rd_data;

  assign dma_we   = dma_we_q;
  assign dma_addr = dma_addr_q;
  assign dma_din  = dma_din_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;

  prg_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({cur_q[13:0], ioctl_dout}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, FIFO handshake and DMA write generation
  always_comb begin
    state_d     = state_q;
    dl_prev_d   = qual_dl;
    load_addr_d = load_addr_q;
    cur_d       = cur_q;
    end_addr_d  = end_addr_q;
    overflow_d  = overflow_q;
    dma_we_d    = 1'b0;
    dma_addr_d  = dma_addr_q;
    dma_din_d   = dma_din_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
`ifdef PRG_PTR_FIXUP_EN
    fix_cnt_d   = fix_cnt_q;
`endif

    // Drain one queued byte per cycle onto the DMA port
    if (!fifo_empty) begin
      fifo_pop   = 1'b1;
      dma_we_d   = 1'b1;
      dma_addr_d = fifo_rd_addr;
      dma_din_d  = fifo_rd_din;
    end

    case (state_q)
      ST_IDLE: begin
        if (dl_rise) begin
          state_d    = ST_HDR_LO;
          overflow_d = 1'b0;
          end_addr_d = 16'd0;
        end
      end

      ST_HDR_LO: begin
        if (!qual_dl) begin
          state_d = ST_DONE;
        end else if (byte_ok && ioctl_addr == 25'd0) begin
          load_addr_d = {load_addr_q[15:8], ioctl_dout};
          state_d     = ST_HDR_HI;
        end
      end

      ST_HDR_HI: begin
        if (!qual_dl) begin
          state_d = ST_DONE;
        end else if (byte_ok && ioctl_addr == 25'd1) begin
          load_addr_d = {ioctl_dout, load_addr_q[7:0]};
          cur_d       = {ioctl_dout, load_addr_q[7:0]};
          state_d     = ST_DATA;
        end
      end

      ST_DATA: begin
        if (byte_ok) begin
          // Target address advances even for dropped bytes, keeping file offsets aligned
          cur_d = cur_inc;
          if (cur_q > RAM_TOP) begin
            overflow_d = 1'b1;
          end else if (fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
          end else begin
            fifo_push = 1'b1;
            if (cur_inc > end_addr_q) end_addr_d = cur_inc;
          end
        end else if (!qual_dl && fifo_empty) begin
`ifdef PRG_PTR_FIXUP_EN
          state_d   = ST_FIXUP;
          fix_cnt_d = 3'd0;
`else
          state_d   = ST_DONE;
`endif
        end
      end

`ifdef PRG_PTR_FIXUP_EN
      ST_FIXUP: begin
        dma_we_d   = 1'b1;
        dma_addr_d = ptr_addr(fix_cnt_q);
        dma_din_d  = fix_cnt_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
        fix_cnt_d  = fix_cnt_q + 3'd1;
        if (fix_cnt_q == 3'd5) state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; dl_prev resets high so a download still active across
  // reset is not mistaken for a new one
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dl_prev_q   <= 1'b1;
      load_addr_q <= 16'd0;
      cur_q       <= 16'd0;
      end_addr_q  <= 16'd0;
      overflow_q  <= 1'b0;
      dma_we_q    <= 1'b0;
      dma_addr_q  <= 14'd0;
      dma_din_q   <= 8'd0;
`ifdef PRG_PTR_FIXUP_EN
      fix_cnt_q   <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      dl_prev_q   <= dl_prev_d;
      load_addr_q <= load_addr_d;
      cur_q       <= cur_d;
      end_addr_q  <= end_addr_d;
      overflow_q  <= overflow_d;
      dma_we_q    <= dma_we_d;
      dma_addr_q  <= dma_addr_d;
      dma_din_q   <= dma_din_d;
`ifdef PRG_PTR_FIXUP_EN
      fix_cnt_q   <= fix_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Bench for prg_dma_loader: a cycle table for the basic load, then
// hand-written sequences for overflow, wrong index, aborted header and reset.
// Honours PRG_PTR_FIXUP_EN when the build defines it.
module tb_prg_dma_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic [13:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prg_dma_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dma_addr       (dma_addr),
    .dma_din        (dma_din),
    .dma_we         (dma_we),
    .busy           (busy),
    .overflow       (overflow)
  );

  typedef struct {
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic [13:0] a;
    logic [7:0]  d;
    logic        bsy;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  vec_t vecs[$];
  wr_t  log_q[$];
  logic [7:0] fb [8];
  int fb_len;

  // Record every DMA write seen on the port
  always @(negedge clk) begin
    if (dma_we === 1'b1) begin
      log_q.push_back('{dma_addr, dma_din});
      $display("dma write addr=%h din=%h", dma_addr, dma_din);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic dl, input logic [7:0] idx,
                      input logic wr, input logic [24:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    reset = rst;
    ioctl_download = dl;
    ioctl_index = idx;
    ioctl_wr = wr;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk);
  endtask

  task automatic add_row(input logic dl, input logic wr, input logic [24:0] a, input logic [7:0] d,
                         input logic we, input logic [13:0] ea, input logic [7:0] ed,
                         input logic b, input logic o);
    vecs.push_back('{dl, wr, a, d, we, ea, ed, b, o});
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy === 1'b1; k++) @(negedge clk);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic load_file();
    step(0, 1, 8'h41, 0, 25'd0, 8'h00);
    for (int i = 0; i < fb_len; i++) step(0, 1, 8'h41, 1, 25'(i), fb[i]);
    step(0, 1, 8'h41, 0, 25'd0, 8'h00);
    step(0, 0, 8'h41, 0, 25'd0, 8'h00);
    wait_idle();
  endtask

  task automatic check_wr(input string name, input int i, input logic [13:0] a, input logic [7:0] d);
    logic [31:0] act;
    act = (i < log_q.size()) ? {10'd0, log_q[i].a, log_q[i].d} : 32'hFFFF_FFFF;
    chk(name, act, {10'd0, a, d});
  endtask

  task automatic check_fixup(input string name, input int base, input logic [15:0] e);
`ifdef PRG_PTR_FIXUP_EN
    for (int k = 0; k < 6; k++)
      check_wr($sformatf("%s_ptr%0d", name, k), base + k, 14'h002A + 14'(k),
               (k % 2 == 1) ? e[15:8] : e[7:0]);
`else
    chk($sformatf("%s_nofix", name), log_q.size(), 32'(base));
    chk($sformatf("%s_end", name), {16'd0, dut.end_addr_q}, {16'd0, e});
`endif
  endtask

  initial begin
    logic [31:0] act, exp;
    int n, busy_any;

    // Basic load 01 04 AA BB CC, one row per cycle; dma_we 2 cycles after ioctl_wr
    add_row(1, 0, 25'd0, 8'h00, 0, 14'h0000, 8'h00, 0, 0);
    add_row(1, 1, 25'd0, 8'h01, 0, 14'h0000, 8'h00, 1, 0);
    add_row(1, 1, 25'd1, 8'h04, 0, 14'h0000, 8'h00, 1, 0);
    add_row(1, 1, 25'd2, 8'hAA, 0, 14'h0000, 8'h00, 1, 0);
    add_row(1, 1, 25'd3, 8'hBB, 0, 14'h0000, 8'h00, 1, 0);
    add_row(1, 1, 25'd4, 8'hCC, 1, 14'h0401, 8'hAA, 1, 0);
    add_row(1, 0, 25'd0, 8'h00, 1, 14'h0402, 8'hBB, 1, 0);
    add_row(0, 0, 25'd0, 8'h00, 1, 14'h0403, 8'hCC, 1, 0);
    add_row(0, 0, 25'd0, 8'h00, 0, 14'h0000, 8'h00, 1, 0);
`ifdef PRG_PTR_FIXUP_EN
    add_row(0, 0, 25'd0, 8'h00, 1, 14'h002A, 8'h04, 1, 0);
    add_row(0, 0, 25'd0, 8'h00, 1, 14'h002B, 8'h04, 1, 0);
    add_row(0, 0, 25'd0, 8'h00, 1, 14'h002C, 8'h04, 1, 0);
    add_row(0, 0, 25'd0, 8'h00, 1, 14'h002D, 8'h04, 1, 0);
    add_row(0, 0, 25'd0, 8'h00, 1, 14'h002E, 8'h04, 1, 0);
    add_row(0, 0, 25'd0, 8'h00, 1, 14'h002F, 8'h04, 1, 0);
`endif
    add_row(0, 0, 25'd0, 8'h00, 0, 14'h0000, 8'h00, 0, 0);

    // Reset state
    step(1, 0, 8'h00, 0, 25'd0, 8'h00);
    step(1, 0, 8'h00, 0, 25'd0, 8'h00);
    step(0, 0, 8'h00, 0, 25'd0, 8'h00);
    chk("reset_outputs", {7'd0, dma_we, busy, overflow, dma_addr, dma_din}, 32'd0);
    chk("reset_end_addr", {16'd0, dut.end_addr_q}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(0, vecs[i].dl, 8'h41, vecs[i].wr, vecs[i].addr, vecs[i].dout);
      act = {7'd0, dma_we, busy, overflow, dma_we ? dma_addr : 14'd0, dma_we ? dma_din : 8'd0};
      exp = {7'd0, vecs[i].we, vecs[i].bsy, vecs[i].ovf,
             vecs[i].we ? vecs[i].a : 14'd0, vecs[i].we ? vecs[i].d : 8'd0};
      chk($sformatf("row%0d", i), act, exp);
      $display("row %0d we=%b addr=%h din=%h busy=%b ovf=%b", i, dma_we, dma_addr, dma_din, busy, overflow);
    end
    chk("basic_end_addr", {16'd0, dut.end_addr_q}, 32'h0000_0404);

    // Load at 3FFE with 4 data bytes: two fit, two are dropped
    log_q.delete();
    fb[0] = 8'hFE; fb[1] = 8'h3F; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h33; fb[5] = 8'h44;
    fb_len = 6;
    load_file();
    check_wr("top_wr0", 0, 14'h3FFE, 8'h11);
    check_wr("top_wr1", 1, 14'h3FFF, 8'h22);
    check_fixup("top", 2, 16'h4000);
    chk("top_overflow", {31'd0, overflow}, 32'd1);
    chk("top_end_addr", {16'd0, dut.end_addr_q}, 32'h0000_4000);
    $display("txn overflow load writes=%0d overflow=%b", log_q.size(), overflow);

    // Foreign slot index: nothing happens, overflow from before is kept
    log_q.delete();
    busy_any = 0;
    step(0, 1, 8'h01, 0, 25'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h01, 1, 25'(i), 8'h55);
      if (busy === 1'b1) busy_any = 1;
    end
    step(0, 0, 8'h01, 0, 25'd0, 8'h00);
    chk("idx_busy", busy_any, 0);
    chk("idx_writes", log_q.size(), 0);
    chk("idx_overflow_kept", {31'd0, overflow}, 32'd1);
    $display("txn wrong index writes=%0d", log_q.size());

    // Download drops after one header byte: DONE with no writes, overflow cleared
    step(0, 1, 8'h41, 0, 25'd0, 8'h00);
    step(0, 1, 8'h41, 1, 25'd0, 8'h01);
    step(0, 0, 8'h41, 0, 25'd0, 8'h00);
    chk("abort_busy_done", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("abort_writes", log_q.size(), 0);
    chk("abort_overflow", {31'd0, overflow}, 32'd0);
    $display("txn aborted header writes=%0d", log_q.size());

    // Next download loads normally
    fb[0] = 8'h01; fb[1] = 8'h04; fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'hCC;
    fb_len = 5;
    load_file();
    check_wr("reload_wr0", 0, 14'h0401, 8'hAA);
    check_wr("reload_wr1", 1, 14'h0402, 8'hBB);
    check_wr("reload_wr2", 2, 14'h0403, 8'hCC);
    check_fixup("reload", 3, 16'h0404);
    chk("reload_overflow", {31'd0, overflow}, 32'd0);
    $display("txn reload writes=%0d", log_q.size());

    // Reset in the middle of a back-to-back data burst
    log_q.delete();
    step(0, 1, 8'h41, 0, 25'd0, 8'h00);
    step(0, 1, 8'h41, 1, 25'd0, 8'h00);
    step(0, 1, 8'h41, 1, 25'd1, 8'h10);
    step(0, 1, 8'h41, 1, 25'd2, 8'hA1);
    step(0, 1, 8'h41, 1, 25'd3, 8'hA2);
    step(0, 1, 8'h41, 1, 25'd4, 8'hA3);
    step(1, 1, 8'h41, 1, 25'd5, 8'hA4);
    step(0, 1, 8'h41, 1, 25'd6, 8'hA5);
    chk("rst_mid_outputs", {7'd0, dma_we, busy, overflow, dma_addr, dma_din}, 32'd0);
    n = log_q.size();
    busy_any = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h41, 1, 25'(7 + i), 8'hB0);
      if (busy === 1'b1) busy_any = 1;
    end
    step(0, 0, 8'h41, 0, 25'd0, 8'h00);
    step(0, 0, 8'h41, 0, 25'd0, 8'h00);
    chk("rst_mid_no_we", log_q.size(), n);
    chk("rst_mid_busy", busy_any, 0);
    $display("txn reset mid-data writes_after_reset=%0d", log_q.size() - n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
